// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: default word configuration and a counter-width helper.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_W_DEF    = 8;
  localparam bit          UART_LSB_FIRST_DEF = 1'b1;
  localparam bit          UART_PAR_ODD_DEF   = 1'b0;

  // Smallest width able to hold values 0..n-1 (at least 1 bit).
  function automatic int unsigned uart_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_deser_n_if.sv
// Handshake bundle between bit sampler / consumer and the RX deserializer.
interface uart_rx_deser_n_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              frame_start;
  logic              deser_en;
  logic              sampled_bit;
  logic              data_ack;
  logic [DATA_W-1:0] P_DATA;
  logic              data_valid;
  logic              par_bit;
  logic              busy;
  logic              ovr_err;

  // Sampler/consumer side.
  modport master (
    output frame_start,
    output deser_en,
    output sampled_bit,
    output data_ack,
    input  P_DATA,
    input  data_valid,
    input  par_bit,
    input  busy,
    input  ovr_err
  );

  // Deserializer side.
  modport slave (
    input  frame_start,
    input  deser_en,
    input  sampled_bit,
    input  data_ack,
    output P_DATA,
    output data_valid,
    output par_bit,
    output busy,
    output ovr_err
  );

endinterface

// File: rtl/uart_rx_deser_n_bit_counter.sv
// Wrap-at-Max counter with synchronous clear and combinational terminal count.
module uart_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned Max   = 8,
  parameter int unsigned Width = uart_clog2(Max + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  localparam logic [Width-1:0] Last = Width'(Max - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; wrap to zero after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == Last);

endmodule

// File: rtl/uart_rx_deser_n.sv
// Parametrised UART RX serial-to-parallel converter with holding register,
// valid/ack handshake, parity and overrun flag.
module uart_rx_deser_n
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = UART_DATA_W_DEF,
  parameter bit          LSB_FIRST = UART_LSB_FIRST_DEF,
  parameter bit          PAR_ODD   = UART_PAR_ODD_DEF
) (
  input logic               clk,
  input logic               rst_n,
  uart_rx_deser_n_if.slave  bus
);

  localparam int unsigned CntW = uart_clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic              valid_q, valid_d;
  logic              par_q, par_d;
  logic              ovr_q, ovr_d;
  logic [CntW-1:0]   cnt;
  logic              tc;
  logic              complete;

  // Bit position counter; frame_start clears it and suppresses a same-cycle strobe.
  uart_bit_counter #(
    .Max   (DATA_W),
    .Width (CntW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.frame_start),
    .en    (bus.deser_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Shift direction selects where the first received bit ends up.
  if (LSB_FIRST) begin : g_lsb_first
    assign word_next = {bus.sampled_bit, shift_q[DATA_W-1:1]};
  end else begin : g_msb_first
    assign word_next = {shift_q[DATA_W-2:0], bus.sampled_bit};
  end

  // Next-state for shift register, holding register and handshake flags.
  always_comb begin
    shift_d  = shift_q;
    pdata_d  = pdata_q;
    par_d    = par_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    if (bus.frame_start) begin
      shift_d = '0;
      ovr_d   = 1'b0;
    end else if (bus.deser_en) begin
      shift_d = word_next;
      if (tc) begin
        complete = 1'b1;
        pdata_d  = word_next;
        par_d    = (^word_next) ^ PAR_ODD;
        valid_d  = 1'b1;
        // A pending, unacknowledged word is being overwritten.
        if (valid_q && !bus.data_ack) begin
          ovr_d = 1'b1;
        end
      end
    end
    // A fresh word takes precedence over an ack in the same cycle.
    if (!complete && bus.data_ack) begin
      valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      pdata_q <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.P_DATA     = pdata_q;
  assign bus.data_valid = valid_q;
  assign bus.par_bit    = par_q;
  assign bus.ovr_err    = ovr_q;
  assign bus.busy       = (cnt != '0);

endmodule

// File: tb/tb_uart_rx_deser_n.sv
// Directed and model-checked bench for uart_rx_deser_n across several configurations.
module tb_uart_rx_deser_n;

  logic clk;
  logic rst_n;
  logic frame_start, deser_en, sampled_bit, data_ack;

  int tests;
  int fails;

  uart_rx_deser_n_if #(.DATA_W(8)) if8  ();
  uart_rx_deser_n_if #(.DATA_W(8)) if8m ();
  uart_rx_deser_n_if #(.DATA_W(7)) if7  ();
  uart_rx_deser_n_if #(.DATA_W(5)) if5  ();
  uart_rx_deser_n_if #(.DATA_W(9)) if9  ();

  assign if8.frame_start  = frame_start;
  assign if8.deser_en     = deser_en;
  assign if8.sampled_bit  = sampled_bit;
  assign if8.data_ack     = data_ack;
  assign if8m.frame_start = frame_start;
  assign if8m.deser_en    = deser_en;
  assign if8m.sampled_bit = sampled_bit;
  assign if8m.data_ack    = data_ack;
  assign if7.frame_start  = frame_start;
  assign if7.deser_en     = deser_en;
  assign if7.sampled_bit  = sampled_bit;
  assign if7.data_ack     = data_ack;
  assign if5.frame_start  = frame_start;
  assign if5.deser_en     = deser_en;
  assign if5.sampled_bit  = sampled_bit;
  assign if5.data_ack     = data_ack;
  assign if9.frame_start  = frame_start;
  assign if9.deser_en     = deser_en;
  assign if9.sampled_bit  = sampled_bit;
  assign if9.data_ack     = data_ack;

  uart_rx_deser_n #(.DATA_W(8), .LSB_FIRST(1'b1), .PAR_ODD(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave));
  uart_rx_deser_n #(.DATA_W(8), .LSB_FIRST(1'b0), .PAR_ODD(1'b0)) u_dut8m (
    .clk(clk), .rst_n(rst_n), .bus(if8m.slave));
  uart_rx_deser_n #(.DATA_W(7), .LSB_FIRST(1'b1), .PAR_ODD(1'b1)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .bus(if7.slave));
  uart_rx_deser_n #(.DATA_W(5), .LSB_FIRST(1'b1), .PAR_ODD(1'b0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5.slave));
  uart_rx_deser_n #(.DATA_W(9), .LSB_FIRST(1'b0), .PAR_ODD(1'b1)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .bus(if9.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    deser_en    = 1'b1;
    sampled_bit = b;
    tick();
    deser_en    = 1'b0;
    sampled_bit = 1'b0;
  endtask

  // Sends seq[n-1] first, down to seq[0].
  task automatic send_seq(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(seq[n-1-i]);
    end
  endtask

  task automatic do_frame_start(input logic ack);
    frame_start = 1'b1;
    data_ack    = ack;
    tick();
    frame_start = 1'b0;
    data_ack    = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({if8.P_DATA, if8.data_valid, if8.par_bit, if8.busy, if8.ovr_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 000",
               {if8.P_DATA, if8.data_valid, if8.par_bit, if8.busy, if8.ovr_err});
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lsb_first();
    do_frame_start(1'b1);
    send_seq(16'b1010010, 7);
    tests++;
    if (if8.busy !== 1'b1 || if8.data_valid !== 1'b0) begin
      fails++;
      $display("FAIL lsb_mid_word: got busy=%b valid=%b expected busy=1 valid=0",
               if8.busy, if8.data_valid);
    end
    send_bit(1'b1);
    tests++;
    if (if8.P_DATA !== 8'hA5 || if8.data_valid !== 1'b1) begin
      fails++;
      $display("FAIL lsb_word: got %h valid=%b expected a5 valid=1", if8.P_DATA, if8.data_valid);
    end
    tests++;
    if (if8.par_bit !== 1'b0 || if8.busy !== 1'b0) begin
      fails++;
      $display("FAIL lsb_par_busy: got par=%b busy=%b expected 0 0", if8.par_bit, if8.busy);
    end
  endtask

  task automatic test_msb_first();
    do_frame_start(1'b1);
    send_seq(16'b11000000, 8);
    tests++;
    if (if8m.P_DATA !== 8'hC0 || if8m.par_bit !== 1'b0) begin
      fails++;
      $display("FAIL msb_word: got %h par=%b expected c0 par=0", if8m.P_DATA, if8m.par_bit);
    end
    tests++;
    if (if8.P_DATA !== 8'h03) begin
      fails++;
      $display("FAIL lsb_word_03: got %h expected 03", if8.P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    do_frame_start(1'b1);
    send_seq(16'b10100101, 8);
    tests++;
    if (if8.P_DATA !== 8'hA5 || if8.data_valid !== 1'b1 || if8.ovr_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got %h valid=%b ovr=%b expected a5 1 0",
               if8.P_DATA, if8.data_valid, if8.ovr_err);
    end
    send_seq(16'b0111000, 7);
    data_ack = 1'b1;
    send_bit(1'b0);
    data_ack = 1'b0;
    tests++;
    if (if8.P_DATA !== 8'h0E || if8.data_valid !== 1'b1 || if8.ovr_err !== 1'b0
        || if8.par_bit !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: got %h valid=%b ovr=%b par=%b expected 0e 1 0 1",
               if8.P_DATA, if8.data_valid, if8.ovr_err, if8.par_bit);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    tests++;
    if (if8.data_valid !== 1'b0 || if8.P_DATA !== 8'h0E) begin
      fails++;
      $display("FAIL ack_clears: got valid=%b data=%h expected 0 0e", if8.data_valid, if8.P_DATA);
    end
  endtask

  task automatic test_overrun();
    do_frame_start(1'b1);
    send_seq(16'b10100101, 8);
    send_seq(16'b11000000, 8);
    tests++;
    if (if8.ovr_err !== 1'b1 || if8.P_DATA !== 8'h03 || if8.data_valid !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got ovr=%b data=%h valid=%b expected 1 03 1",
               if8.ovr_err, if8.P_DATA, if8.data_valid);
    end
    do_frame_start(1'b0);
    tests++;
    if (if8.ovr_err !== 1'b0 || if8.data_valid !== 1'b1) begin
      fails++;
      $display("FAIL overrun_clear: got ovr=%b valid=%b expected 0 1", if8.ovr_err, if8.data_valid);
    end
  endtask

  task automatic test_frame_priority();
    do_frame_start(1'b1);
    send_seq(16'b111, 3);
    frame_start = 1'b1;
    deser_en    = 1'b1;
    sampled_bit = 1'b1;
    tick();
    frame_start = 1'b0;
    deser_en    = 1'b0;
    sampled_bit = 1'b0;
    tests++;
    if (if8.busy !== 1'b0 || if8.P_DATA !== 8'h03 || if8.data_valid !== 1'b0) begin
      fails++;
      $display("FAIL fs_priority: got busy=%b data=%h valid=%b expected 0 03 0",
               if8.busy, if8.P_DATA, if8.data_valid);
    end
    send_seq(16'b10100101, 8);
    tests++;
    if (if8.P_DATA !== 8'hA5 || if8.data_valid !== 1'b1) begin
      fails++;
      $display("FAIL fs_full_word: got %h valid=%b expected a5 1", if8.P_DATA, if8.data_valid);
    end
    do_frame_start(1'b0);
    send_seq(16'b1011, 4);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({if8.P_DATA, if8.data_valid, if8.par_bit, if8.busy, if8.ovr_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid_word: got %h expected 000",
               {if8.P_DATA, if8.data_valid, if8.par_bit, if8.busy, if8.ovr_err});
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_width7_odd();
    do_frame_start(1'b1);
    send_seq(16'b1110000, 7);
    tests++;
    if (if7.P_DATA !== 7'h07 || if7.par_bit !== 1'b0 || if7.data_valid !== 1'b1) begin
      fails++;
      $display("FAIL w7_odd: got %h par=%b valid=%b expected 07 0 1",
               if7.P_DATA, if7.par_bit, if7.data_valid);
    end
  endtask

  task automatic test_random();
    int          w  [3];
    bit          lsb[3];
    bit          odd[3];
    logic [8:0]  m_sh[3];
    logic [8:0]  m_pd[3];
    logic [8:0]  mask;
    int          m_cnt[3];
    logic        m_v[3];
    logic        m_par[3];
    logic        m_ovr[3];
    logic [12:0] act[3];
    logic [12:0] exp_v;
    int          bad;
    w   = '{5, 8, 9};
    lsb = '{1'b1, 1'b1, 1'b0};
    odd = '{1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_sh[k] = '0; m_pd[k] = '0; m_cnt[k] = 0;
      m_v[k] = 1'b0; m_par[k] = 1'b0; m_ovr[k] = 1'b0;
    end
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      frame_start = ($urandom_range(0, 39) == 0);
      deser_en    = ($urandom_range(0, 3) != 0);
      sampled_bit = 1'($urandom_range(0, 1));
      data_ack    = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) begin
        mask = (9'h1 << w[k]) - 9'h1;
        if (frame_start) begin
          m_cnt[k] = 0;
          m_sh[k]  = '0;
          m_ovr[k] = 1'b0;
          if (data_ack) m_v[k] = 1'b0;
        end else if (deser_en) begin
          if (lsb[k]) m_sh[k] = (m_sh[k] >> 1) | (9'(sampled_bit) << (w[k] - 1));
          else        m_sh[k] = ((m_sh[k] << 1) | 9'(sampled_bit)) & mask;
          if (m_cnt[k] == w[k] - 1) begin
            m_pd[k]  = m_sh[k];
            m_par[k] = (^m_sh[k]) ^ odd[k];
            if (m_v[k] && !data_ack) m_ovr[k] = 1'b1;
            m_v[k]   = 1'b1;
            m_cnt[k] = 0;
          end else begin
            m_cnt[k]++;
            if (data_ack) m_v[k] = 1'b0;
          end
        end else if (data_ack) begin
          m_v[k] = 1'b0;
        end
      end
      tick();
      act[0] = {9'(if5.P_DATA), if5.data_valid, if5.par_bit, if5.busy, if5.ovr_err};
      act[1] = {9'(if8.P_DATA), if8.data_valid, if8.par_bit, if8.busy, if8.ovr_err};
      act[2] = {9'(if9.P_DATA), if9.data_valid, if9.par_bit, if9.busy, if9.ovr_err};
      for (int k = 0; k < 3; k++) begin
        exp_v = {m_pd[k], m_v[k], m_par[k], (m_cnt[k] != 0), m_ovr[k]};
        tests++;
        if (act[k] !== exp_v) begin
          fails++;
          if (bad < 10) begin
            $display("FAIL random_w%0d cycle %0d: got %h expected %h", w[k], c, act[k], exp_v);
          end
          bad++;
        end
      end
    end
    frame_start = 1'b0;
    deser_en    = 1'b0;
    sampled_bit = 1'b0;
    data_ack    = 1'b0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b1;
    frame_start = 1'b0;
    deser_en    = 1'b0;
    sampled_bit = 1'b0;
    data_ack    = 1'b0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_overrun();
    test_frame_priority();
    test_width7_odd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
